// File: rtl/slv_mem_pkg.sv
// Shared constants and helpers for the slv_mem register-file slave.
// Holds the legal read-latency range and a check used at elaboration.
package slv_mem_pkg;

    localparam int MIN_RD_LATENCY = 1;
    localparam int MAX_RD_LATENCY = 4;

    function automatic bit rd_latency_ok(int lat);
        return (lat >= MIN_RD_LATENCY) && (lat <= MAX_RD_LATENCY);
    endfunction

endpackage

// File: rtl/simple_if.sv
// Simple single-master bus: address, read/write strobes, write data
// from the master; read data returned by the slave.
interface simple_if #(
    parameter int ADDR_BIT_WIDTH = 2,
    parameter int DATA_BIT_WIDTH = 8
);
    logic [ADDR_BIT_WIDTH-1:0] addr;
    logic                      rd_req;
    logic                      wr_req;
    logic [DATA_BIT_WIDTH-1:0] wr_data;
    logic [DATA_BIT_WIDTH-1:0] rd_data;

    modport mst_port (
        output addr, rd_req, wr_req, wr_data,
        input  rd_data
    );

    modport slv_port (
        input  addr, rd_req, wr_req, wr_data,
        output rd_data
    );
endinterface

// File: rtl/vld_dly_line.sv
// Valid/data shift-register delay line of DELAY stages (0 = wire).
// Ports: i_clk, i_sync_rst, i_vld/i_data in; o_vld/o_data out.
module vld_dly_line #(
    parameter int DELAY          = 0,
    parameter int DATA_BIT_WIDTH = 8
) (
    input  logic                      i_clk,
    input  logic                      i_sync_rst,
    input  logic                      i_vld,
    input  logic [DATA_BIT_WIDTH-1:0] i_data,
    output logic                      o_vld,
    output logic [DATA_BIT_WIDTH-1:0] o_data
);

    if (DELAY == 0) begin : g_pass
        logic unused_ok;
        assign unused_ok = ^{i_clk, i_sync_rst};
        assign o_vld     = i_vld;
        assign o_data    = i_data;
    end else begin : g_pipe
        logic [DELAY-1:0]          vld_q;
        logic [DELAY:0]            vld_nx;
        logic [DATA_BIT_WIDTH-1:0] data_q [DELAY];

        assign vld_nx = {vld_q, i_vld};

        // Only valid bits are flushed; data is qualified by them.
        always_ff @(posedge i_clk) begin
            if (i_sync_rst) begin
                vld_q <= '0;
            end else begin
                vld_q <= vld_nx[DELAY-1:0];
            end
        end

        always_ff @(posedge i_clk) begin
            data_q[0] <= i_data;
            for (int i = 1; i < DELAY; i++) begin
                data_q[i] <= data_q[i-1];
            end
        end

        assign o_vld  = vld_q[DELAY-1];
        assign o_data = data_q[DELAY-1];
    end

endmodule

// File: rtl/slv_mem.sv
// Register-file slave memory with pipelined read return.
// Ports: i_clk, i_sync_rst, if_bus (slave side), o_rd_vld,
//        o_wr_cnt/o_rd_cnt saturating counters, o_err sticky error.
module slv_mem
    import slv_mem_pkg::*;
#(
    parameter int ADDR_BIT_WIDTH = 2,
    parameter int DATA_BIT_WIDTH = 8,
    parameter int RD_LATENCY     = 1,
    parameter int CNT_BIT_WIDTH  = 16
) (
    input  logic                     i_clk,
    input  logic                     i_sync_rst,
    simple_if.slv_port               if_bus,
    output logic                     o_rd_vld,
    output logic [CNT_BIT_WIDTH-1:0] o_wr_cnt,
    output logic [CNT_BIT_WIDTH-1:0] o_rd_cnt,
    output logic                     o_err
);

    if (!rd_latency_ok(RD_LATENCY)) begin : g_bad_latency
        $fatal(1, "slv_mem: RD_LATENCY out of range 1..4");
    end

    typedef struct packed {
        logic                      vld;
        logic [DATA_BIT_WIDTH-1:0] data;
    } rd_pipe_entry_t;

    localparam int DEPTH = 2 ** ADDR_BIT_WIDTH;

    logic [DATA_BIT_WIDTH-1:0] mem [DEPTH];
    rd_pipe_entry_t            smp_q;
    logic                      dly_vld;
    logic [DATA_BIT_WIDTH-1:0] dly_data;
    logic [DATA_BIT_WIDTH-1:0] hold_q;
    logic                      wr_acc;
    logic                      rd_acc;
    logic                      collide;

    // A simultaneous read is dropped so the write always wins.
    always_comb begin
        wr_acc  = if_bus.wr_req;
        collide = if_bus.rd_req & if_bus.wr_req;
        rd_acc  = if_bus.rd_req & ~if_bus.wr_req;
    end

    always_ff @(posedge i_clk) begin
        if (i_sync_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_acc) begin
            mem[if_bus.addr] <= if_bus.wr_data;
        end
    end

    // Sampling register: first stage of the read pipeline.
    always_ff @(posedge i_clk) begin
        if (i_sync_rst) begin
            smp_q <= '0;
        end else begin
            smp_q.vld <= rd_acc;
            if (rd_acc) begin
                smp_q.data <= mem[if_bus.addr];
            end
        end
    end

    vld_dly_line #(
        .DELAY          (RD_LATENCY - 1),
        .DATA_BIT_WIDTH (DATA_BIT_WIDTH)
    ) u_dly (
        .i_clk      (i_clk),
        .i_sync_rst (i_sync_rst),
        .i_vld      (smp_q.vld),
        .i_data     (smp_q.data),
        .o_vld      (dly_vld),
        .o_data     (dly_data)
    );

    // Remembers the last returned word so rd_data is stable between
    // results without adding a cycle to the read path.
    always_ff @(posedge i_clk) begin
        if (i_sync_rst) begin
            hold_q <= '0;
        end else if (dly_vld) begin
            hold_q <= dly_data;
        end
    end

    assign if_bus.rd_data = dly_vld ? dly_data : hold_q;
    assign o_rd_vld       = dly_vld;

    always_ff @(posedge i_clk) begin
        if (i_sync_rst) begin
            o_wr_cnt <= '0;
            o_rd_cnt <= '0;
            o_err    <= 1'b0;
        end else begin
            if (wr_acc && (o_wr_cnt != '1)) begin
                o_wr_cnt <= o_wr_cnt + CNT_BIT_WIDTH'(1);
            end
            if (rd_acc && (o_rd_cnt != '1)) begin
                o_rd_cnt <= o_rd_cnt + CNT_BIT_WIDTH'(1);
            end
            if (collide) begin
                o_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_slv_mem.sv
// Self-checking bench for slv_mem: latency 1, 3 and 4 instances driven
// by one stimulus stream; table vectors plus corner-case sequences.
module tb_slv_mem;

    logic       i_clk = 1'b0;
    logic       rst   = 1'b0;
    logic       rd    = 1'b0;
    logic       wr    = 1'b0;
    logic [1:0] addr  = '0;
    logic [7:0] wd    = '0;

    logic        vld_a, vld_b, vld_c;
    logic [15:0] wc_a, rc_a, wc_b, rc_b;
    logic [2:0]  wc_c, rc_c;
    logic        err_a, err_b, err_c;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 i_clk = ~i_clk;

    simple_if #(.ADDR_BIT_WIDTH(2), .DATA_BIT_WIDTH(8)) bus_a ();
    simple_if #(.ADDR_BIT_WIDTH(2), .DATA_BIT_WIDTH(8)) bus_b ();
    simple_if #(.ADDR_BIT_WIDTH(2), .DATA_BIT_WIDTH(8)) bus_c ();

    assign bus_a.addr = addr;
    assign bus_a.rd_req = rd;
    assign bus_a.wr_req = wr;
    assign bus_a.wr_data = wd;
    assign bus_b.addr = addr;
    assign bus_b.rd_req = rd;
    assign bus_b.wr_req = wr;
    assign bus_b.wr_data = wd;
    assign bus_c.addr = addr;
    assign bus_c.rd_req = rd;
    assign bus_c.wr_req = wr;
    assign bus_c.wr_data = wd;

    slv_mem #(.RD_LATENCY(1), .CNT_BIT_WIDTH(16)) dut_a (
        .i_clk(i_clk), .i_sync_rst(rst), .if_bus(bus_a.slv_port),
        .o_rd_vld(vld_a), .o_wr_cnt(wc_a), .o_rd_cnt(rc_a), .o_err(err_a)
    );

    slv_mem #(.RD_LATENCY(3), .CNT_BIT_WIDTH(16)) dut_b (
        .i_clk(i_clk), .i_sync_rst(rst), .if_bus(bus_b.slv_port),
        .o_rd_vld(vld_b), .o_wr_cnt(wc_b), .o_rd_cnt(rc_b), .o_err(err_b)
    );

    slv_mem #(.RD_LATENCY(4), .CNT_BIT_WIDTH(3)) dut_c (
        .i_clk(i_clk), .i_sync_rst(rst), .if_bus(bus_c.slv_port),
        .o_rd_vld(vld_c), .o_wr_cnt(wc_c), .o_rd_cnt(rc_c), .o_err(err_c)
    );

    typedef struct {
        logic        rst, rd, wr;
        logic [1:0]  addr;
        logic [7:0]  wd;
        logic        va;
        logic [7:0]  da;
        logic [15:0] wc, rc;
        logic        err;
        logic        vb;
        logic [7:0]  db;
    } vec_t;

    vec_t tbl [28];

    function automatic vec_t mk(
        logic r, logic rq, logic wq, logic [1:0] a, logic [7:0] w,
        logic va, logic [7:0] da, logic [15:0] wc, logic [15:0] rc,
        logic e, logic vb, logic [7:0] db);
        vec_t v;
        v.rst = r; v.rd = rq; v.wr = wq; v.addr = a; v.wd = w;
        v.va = va; v.da = da; v.wc = wc; v.rc = rc; v.err = e;
        v.vb = vb; v.db = db;
        return v;
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(logic r, logic rq, logic wq,
                         logic [1:0] a, logic [7:0] w);
        rst = r; rd = rq; wr = wq; addr = a; wd = w;
    endtask

    initial begin
        //            rst rd wr a  wd     va da     wc  rc  er vb db
        tbl[0]  = mk(1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00);
        tbl[1]  = mk(1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00);
        tbl[2]  = mk(1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00);
        tbl[3]  = mk(0, 1, 0, 0, 8'h00, 1, 8'h00, 0, 1, 0, 0, 8'h00);
        tbl[4]  = mk(0, 1, 0, 1, 8'h00, 1, 8'h00, 0, 2, 0, 0, 8'h00);
        tbl[5]  = mk(0, 1, 0, 2, 8'h00, 1, 8'h00, 0, 3, 0, 1, 8'h00);
        tbl[6]  = mk(0, 1, 0, 3, 8'h00, 1, 8'h00, 0, 4, 0, 1, 8'h00);
        tbl[7]  = mk(0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 4, 0, 1, 8'h00);
        tbl[8]  = mk(0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 4, 0, 1, 8'h00);
        tbl[9]  = mk(0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 4, 0, 0, 8'h00);
        tbl[10] = mk(1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00);
        tbl[11] = mk(0, 0, 1, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h00);
        tbl[12] = mk(0, 0, 1, 1, 8'h01, 0, 8'h00, 2, 0, 0, 0, 8'h00);
        tbl[13] = mk(0, 0, 1, 2, 8'h02, 0, 8'h00, 3, 0, 0, 0, 8'h00);
        tbl[14] = mk(0, 0, 1, 3, 8'h03, 0, 8'h00, 4, 0, 0, 0, 8'h00);
        tbl[15] = mk(0, 1, 0, 0, 8'h00, 1, 8'h00, 4, 1, 0, 0, 8'h00);
        tbl[16] = mk(0, 1, 0, 1, 8'h00, 1, 8'h01, 4, 2, 0, 0, 8'h00);
        tbl[17] = mk(0, 1, 0, 2, 8'h00, 1, 8'h02, 4, 3, 0, 1, 8'h00);
        tbl[18] = mk(0, 1, 0, 3, 8'h00, 1, 8'h03, 4, 4, 0, 1, 8'h01);
        tbl[19] = mk(0, 0, 0, 0, 8'h00, 0, 8'h03, 4, 4, 0, 1, 8'h02);
        tbl[20] = mk(0, 0, 0, 0, 8'h00, 0, 8'h03, 4, 4, 0, 1, 8'h03);
        tbl[21] = mk(0, 0, 0, 0, 8'h00, 0, 8'h03, 4, 4, 0, 0, 8'h03);
        tbl[22] = mk(0, 0, 1, 1, 8'h3C, 0, 8'h03, 5, 4, 0, 0, 8'h03);
        tbl[23] = mk(0, 1, 0, 1, 8'h00, 1, 8'h3C, 5, 5, 0, 0, 8'h03);
        tbl[24] = mk(0, 1, 1, 2, 8'hA5, 0, 8'h3C, 6, 5, 1, 0, 8'h03);
        tbl[25] = mk(0, 1, 0, 2, 8'h00, 1, 8'hA5, 6, 6, 1, 1, 8'h3C);
        tbl[26] = mk(0, 0, 0, 0, 8'h00, 0, 8'hA5, 6, 6, 1, 0, 8'h3C);
        tbl[27] = mk(0, 0, 0, 0, 8'h00, 0, 8'hA5, 6, 6, 1, 1, 8'hA5);

        @(negedge i_clk);
        for (int i = 0; i < 28; i++) begin
            drive(tbl[i].rst, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd);
            tick();
            check($sformatf("row%0d a_vld", i), 32'(vld_a), 32'(tbl[i].va));
            check($sformatf("row%0d a_data", i), 32'(bus_a.rd_data),
                  32'(tbl[i].da));
            check($sformatf("row%0d a_wcnt", i), 32'(wc_a), 32'(tbl[i].wc));
            check($sformatf("row%0d a_rcnt", i), 32'(rc_a), 32'(tbl[i].rc));
            check($sformatf("row%0d a_err", i), 32'(err_a), 32'(tbl[i].err));
            check($sformatf("row%0d b_vld", i), 32'(vld_b), 32'(tbl[i].vb));
            check($sformatf("row%0d b_data", i), 32'(bus_b.rd_data),
                  32'(tbl[i].db));
        end

        // Sticky error survives 10 clean cycles, clears on reset.
        drive(0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("err_sticky%0d", i), 32'(err_a), 32'd1);
        end
        drive(1, 0, 0, 0, 8'h00);
        tick();
        check("err_reset", 32'(err_a), 32'd0);
        check("b_err_reset", 32'(err_b), 32'd0);

        // Reset mid-read on the latency-4 instance.
        drive(0, 0, 1, 1, 8'h77);
        tick();
        drive(0, 1, 0, 1, 8'h00);
        tick();
        check("c_midrd_t0", 32'(vld_c), 32'd0);
        drive(0, 0, 0, 0, 8'h00);
        tick();
        check("c_midrd_t1", 32'(vld_c), 32'd0);
        drive(1, 0, 0, 0, 8'h00);
        tick();
        check("c_midrd_t2", 32'(vld_c), 32'd0);
        tick();
        check("c_midrd_t3", 32'(vld_c), 32'd0);
        drive(0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("c_flushed%0d", i), 32'(vld_c), 32'd0);
        end
        drive(0, 1, 0, 1, 8'h00);
        tick();
        drive(0, 0, 0, 0, 8'h00);
        for (int i = 1; i < 4; i++) begin
            check($sformatf("c_lat_gap%0d", i), 32'(vld_c), 32'd0);
            tick();
        end
        check("c_rd_vld", 32'(vld_c), 32'd1);
        check("c_rd_zero", 32'(bus_c.rd_data), 32'h00);
        check("c_rcnt", 32'(rc_c), 32'd1);
        tick();
        check("c_vld_1cyc", 32'(vld_c), 32'd0);

        // Write-counter saturation on the 3-bit counter instance.
        drive(1, 0, 0, 0, 8'h00);
        tick();
        check("c_wcnt_rst", 32'(wc_c), 32'd0);
        for (int k = 1; k <= 9; k++) begin
            drive(0, 0, 1, 2'(k), 8'(k));
            tick();
            check($sformatf("c_wcnt_w%0d", k), 32'(wc_c),
                  32'((k > 7) ? 7 : k));
        end
        check("c_rcnt_idle", 32'(rc_c), 32'd0);
        drive(0, 0, 0, 0, 8'h00);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
